uart_rx_fifo_less_v2: RTL

//  Second-generation oversampling UART receiver for the Wishbone UART slave.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_fifo_less_v2.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, parity
// mode codes and the three-sample majority voter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the
// idle (high) level so no false start bit is seen after reset.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_fifo_less_v2.sv
// Oversampling UART receiver with majority-vote bit sampling, false-start
// rejection, error flags and a single valid/ready holding register.
module uart_rx_fifo_less_v2
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 bd_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OVS / 2 + 1);

    logic rx_s;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_t            state_reg, state_next;
    logic [TW-1:0]        tcnt_reg, tcnt_next;
    logic [BW-1:0]        bcnt_reg, bcnt_next;
    logic                 scnt_reg, scnt_next;
    logic [DATA_BITS-1:0] shreg_reg, shreg_next;
    logic                 par_reg, par_next;
    logic [1:0]           samp_reg, samp_next;
    logic                 frame_bad_reg, frame_bad_next;
    logic                 stop_one_reg, stop_one_next;
    logic                 commit;
    logic                 vote;
    logic                 parity_c, frame_c, break_c;

    // Third sample is taken live, so the vote is ready on the T_S2 tick itself.
    assign vote = vote3(samp_reg[1], samp_reg[0], rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            tcnt_reg      <= '0;
            bcnt_reg      <= '0;
            scnt_reg      <= 1'b0;
            shreg_reg     <= '0;
            par_reg       <= 1'b0;
            samp_reg      <= 2'b11;
            frame_bad_reg <= 1'b0;
            stop_one_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tcnt_reg      <= tcnt_next;
            bcnt_reg      <= bcnt_next;
            scnt_reg      <= scnt_next;
            shreg_reg     <= shreg_next;
            par_reg       <= par_next;
            samp_reg      <= samp_next;
            frame_bad_reg <= frame_bad_next;
            stop_one_reg  <= stop_one_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tcnt_next      = tcnt_reg;
        bcnt_next      = bcnt_reg;
        scnt_next      = scnt_reg;
        shreg_next     = shreg_reg;
        par_next       = par_reg;
        samp_next      = samp_reg;
        frame_bad_next = frame_bad_reg;
        stop_one_next  = stop_one_reg;
        commit         = 1'b0;
        if (bd_tick) begin
            if (state_reg != IDLE && state_reg != WAIT_HIGH) begin
                tcnt_next = (tcnt_reg == T_LAST) ? '0 : tcnt_reg + 1'b1;
                if (tcnt_reg == T_S0) samp_next[1] = rx_s;
                if (tcnt_reg == T_S1) samp_next[0] = rx_s;
            end
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next     = START;
                        tcnt_next      = '0;
                        scnt_next      = 1'b0;
                        par_next       = 1'b0;
                        frame_bad_next = 1'b0;
                        stop_one_next  = 1'b0;
                    end
                end
                START: begin
                    if (tcnt_reg == T_S2 && vote) begin
                        state_next = IDLE;
                        tcnt_next  = '0;
                    end else if (tcnt_reg == T_LAST) begin
                        state_next = DATA;
                        bcnt_next  = '0;
                    end
                end
                DATA: begin
                    if (tcnt_reg == T_S2) shreg_next = {vote, shreg_reg[DATA_BITS-1:1]};
                    if (tcnt_reg == T_LAST) begin
                        if (bcnt_reg == BW'(DATA_BITS - 1)) begin
                            state_next = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bcnt_next = bcnt_reg + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tcnt_reg == T_S2) par_next = vote;
                    if (tcnt_reg == T_LAST) state_next = STOP;
                end
                STOP: begin
                    if (tcnt_reg == T_S2) begin
                        if (scnt_reg == 1'(STOP_BITS - 1)) begin
                            // Finishing mid-bit leaves half a bit to catch the next start edge.
                            commit     = 1'b1;
                            state_next = vote ? IDLE : WAIT_HIGH;
                            tcnt_next  = '0;
                        end else begin
                            frame_bad_next = frame_bad_reg | ~vote;
                            stop_one_next  = stop_one_reg | vote;
                        end
                    end else if (tcnt_reg == T_LAST) begin
                        scnt_next = 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign parity_c = (PARITY_MODE != PAR_NONE) &&
                      ((^shreg_reg ^ par_reg) != (PARITY_MODE == PAR_ODD));
    assign frame_c  = frame_bad_reg | ~vote;
    assign break_c  = (shreg_reg == '0) && ((PARITY_MODE == PAR_NONE) || !par_reg) &&
                      !stop_one_reg && !vote;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (commit) begin
            rx_data     <= shreg_reg;
            rx_valid    <= 1'b1;
            parity_err  <= parity_c;
            frame_err   <= frame_c;
            break_err   <= break_c;
            overrun_err <= rx_valid;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule
